// File: rtl/bram_stream_fifo_pkg.sv
// rtl/bram_stream_fifo_pkg.sv - shared defaults and prefetch-stage occupancy encoding
package bram_stream_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    STG_EMPTY = 2'd0,
    STG_ONE   = 2'd1,
    STG_TWO   = 2'd2
  } stage_occ_e;

endpackage

// File: rtl/bram_stream_fifo_dual_port_bram.sv
// rtl/bram_stream_fifo_dual_port_bram.sv - simple dual-port RAM, registered reads, read-before-write
module dual_port_bram
  import bram_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_en,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Reads sample the array before this edge's writes land, so collisions return old data.
  always_ff @(posedge clk) begin
    a_rdata <= mem[a_addr];
    if (b_en) b_rdata <= mem[b_addr];
    if (a_wr) mem[a_addr] <= a_wdata;
    if (b_wr) mem[b_addr] <= b_wdata;
  end

endmodule

// File: rtl/bram_stream_fifo.sv
// rtl/bram_stream_fifo.sv - BRAM-backed first-word-fall-through stream FIFO with 2-entry prefetch stage
module bram_stream_fifo
  import bram_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d, count_q, count_d;
  logic                  inflight_q, in_ready_q;
  stage_occ_e            occ_q;
  logic [DATA_WIDTH-1:0] head_q, skid_q, bram_rdata, unused_a_rdata;
  logic                  push, pop, rd_en;
  logic [2:0]            pending;

  assign push        = i_in_valid && in_ready_q;
  assign pop         = (occ_q != STG_EMPTY) && i_out_ready;
  assign o_in_ready  = in_ready_q;
  assign o_out_valid = (occ_q != STG_EMPTY);
  assign o_out_data  = head_q;
  assign o_count     = count_q;
  assign o_empty     = (count_q == '0);
  assign o_full      = (count_q == DEPTH_C);

  // Slots the stage will hold after this edge, including the read already on its way.
  assign pending = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign rd_en   = (mem_cnt_q != '0) && (pending < 3'd2);

  always_comb begin
    wr_ptr_d  = push  ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d  = rd_en ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q;
    if (push && !rd_en) mem_cnt_d = mem_cnt_q + (ADDR_WIDTH+1)'(1);
    else if (!push && rd_en) mem_cnt_d = mem_cnt_q - (ADDR_WIDTH+1)'(1);
    count_d = count_q;
    if (push && !pop) count_d = count_q + (ADDR_WIDTH+1)'(1);
    else if (!push && pop) count_d = count_q - (ADDR_WIDTH+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      count_q    <= count_d;
      inflight_q <= rd_en;
      in_ready_q <= (count_d != DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q  <= STG_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      unique case (occ_q)
        STG_EMPTY: begin
          if (inflight_q) begin
            head_q <= bram_rdata;
            occ_q  <= STG_ONE;
          end
        end
        STG_ONE: begin
          if (inflight_q && pop) begin
            head_q <= bram_rdata;
          end else if (inflight_q) begin
            skid_q <= bram_rdata;
            occ_q  <= STG_TWO;
          end else if (pop) begin
            occ_q  <= STG_EMPTY;
          end
        end
        STG_TWO: begin
          if (pop) begin
            head_q <= skid_q;
            if (inflight_q) skid_q <= bram_rdata;
            else occ_q <= STG_ONE;
          end
        end
        default: occ_q <= STG_EMPTY;
      endcase
    end
  end

  dual_port_bram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bram (
    .clk    (clk),
    .a_wr   (push),
    .a_addr (wr_ptr_q),
    .a_wdata(i_in_data),
    .a_rdata(unused_a_rdata),
    .b_en   (rd_en),
    .b_wr   (1'b0),
    .b_addr (rd_ptr_q),
    .b_wdata('0),
    .b_rdata(bram_rdata)
  );

endmodule

// File: tb/tb_bram_stream_fifo.sv
// tb/tb_bram_stream_fifo.sv - directed and scoreboard bench for bram_stream_fifo
module tb_bram_stream_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [DW-1:0] i_in_data;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [DW-1:0] o_out_data;
  logic [AW:0]   o_count;
  logic          o_empty;
  logic          o_full;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] q[$];
  int          sent, got, cyc, wr;
  logic        acc, stall;
  logic [31:0] stall_data;

  always #5 clk = ~clk;

  bram_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_data  (i_in_data),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_data (o_out_data),
    .o_count    (o_count),
    .o_empty    (o_empty),
    .o_full     (o_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0; i_in_data = '0;
    step(); step();
    chk("rst_out_valid", 32'(o_out_valid), 0);
    chk("rst_in_ready",  32'(o_in_ready), 0);
    chk("rst_empty",     32'(o_empty), 1);
    chk("rst_full",      32'(o_full), 0);
    chk("rst_count",     32'(o_count), 0);
    chk("rst_out_data",  o_out_data, 0);
    rst = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(o_in_ready), 1);

    // single word latency
    i_in_data = 32'h11; i_in_valid = 1'b1; i_out_ready = 1'b1;
    step();
    i_in_valid = 1'b0;
    chk("lat_valid_n",   32'(o_out_valid), 0);
    chk("lat_count_n",   32'(o_count), 1);
    step();
    chk("lat_valid_n1",  32'(o_out_valid), 0);
    step();
    chk("lat_valid_n2",  32'(o_out_valid), 1);
    chk("lat_data_n2",   o_out_data, 32'h11);
    step();
    chk("lat_empty",     32'(o_empty), 1);
    chk("lat_valid_end", 32'(o_out_valid), 0);

    // fill to full, overflow attempt, drain
    i_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      i_in_data = 32'(i); i_in_valid = 1'b1;
      step();
    end
    chk("fill_full",     32'(o_full), 1);
    chk("fill_count",    32'(o_count), 16);
    chk("fill_in_ready", 32'(o_in_ready), 0);
    i_in_data = 32'h99;
    step();
    i_in_valid = 1'b0;
    chk("ovf_count", 32'(o_count), 16);
    chk("ovf_head",  o_out_data, 0);
    i_out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_valid", 32'(o_out_valid), 1);
      chk("drain_data",  o_out_data, 32'(k));
      step();
    end
    chk("drain_valid_end", 32'(o_out_valid), 0);
    chk("drain_empty",     32'(o_empty), 1);
    step();
    chk("drain_no_extra",  32'(o_out_valid), 0);

    // continuous streaming of 100 words
    i_in_valid = 1'b1; i_out_ready = 1'b1; i_in_data = '0; wr = 0;
    for (int c = 0; c < 104; c++) begin
      acc = i_in_valid && o_in_ready;
      step();
      if (acc) wr++;
      i_in_data  = 32'(wr);
      i_in_valid = (wr < 100);
      if (c >= 2 && c <= 101) begin
        chk("stream_valid", 32'(o_out_valid), 1);
        chk("stream_data",  o_out_data, 32'(c - 2));
      end
      if (c >= 2 && c <= 99) chk("stream_count", 32'(o_count), 3);
    end
    chk("stream_empty", 32'(o_empty), 1);
    chk("stream_valid_end", 32'(o_out_valid), 0);

    // random handshakes against a scoreboard
    sent = 0; got = 0; cyc = 0; stall = 1'b0; stall_data = '0;
    while (got < 2000 && cyc < 20000) begin
      i_in_valid  = (sent < 2000) && ($urandom_range(0, 1) == 1);
      i_out_ready = ($urandom_range(0, 1) == 1);
      i_in_data   = $urandom;
      if (stall) begin
        chk("hold_valid", 32'(o_out_valid), 1);
        chk("hold_data",  o_out_data, stall_data);
      end
      if (o_out_valid && i_out_ready) begin
        if (q.size() == 0) chk("spurious_valid", 32'(o_out_valid), 0);
        else begin
          chk("rnd_data", o_out_data, q.pop_front());
          got++;
        end
      end
      if (i_in_valid && o_in_ready) begin
        q.push_back(i_in_data);
        sent++;
      end
      stall      = o_out_valid && !i_out_ready;
      stall_data = o_out_data;
      step();
      cyc++;
      chk("rnd_count",    32'(o_count), 32'(q.size()));
      chk("rnd_in_ready", 32'(o_in_ready), 32'(q.size() < DEPTH));
    end
    if (got < 2000) chk("rnd_timeout", 32'(got), 2000);
    i_in_valid = 1'b0; i_out_ready = 1'b1;
    step(); step(); step();
    chk("rnd_empty", 32'(o_empty), 1);

    // full with simultaneous push and pop
    i_out_ready = 1'b0; i_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_in_data = 32'h100 + 32'(i);
      step();
    end
    chk("full2_full", 32'(o_full), 1);
    i_in_data = 32'hDEAD; i_out_ready = 1'b1;
    step();
    i_in_valid = 1'b0; i_out_ready = 1'b0;
    chk("full2_count",    32'(o_count), 15);
    chk("full2_in_ready", 32'(o_in_ready), 1);
    chk("full2_full_off", 32'(o_full), 0);
    chk("full2_head",     o_out_data, 32'h101);
    i_out_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      chk("full2_drain_valid", 32'(o_out_valid), 1);
      chk("full2_drain_data",  o_out_data, 32'h100 + 32'(k));
      step();
    end
    chk("full2_empty", 32'(o_empty), 1);

    // reset with words held and a prefetch in flight
    i_out_ready = 1'b0; i_in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      i_in_data = 32'h200 + 32'(i);
      step();
    end
    i_in_valid = 1'b0;
    step(); step(); step();
    i_in_valid = 1'b1; i_in_data = 32'h207; i_out_ready = 1'b1;
    step();
    chk("prerst_count", 32'(o_count), 7);
    i_in_valid = 1'b0; i_out_ready = 1'b0; rst = 1'b0;
    step();
    chk("midrst_valid",    32'(o_out_valid), 0);
    chk("midrst_count",    32'(o_count), 0);
    chk("midrst_empty",    32'(o_empty), 1);
    chk("midrst_in_ready", 32'(o_in_ready), 0);
    rst = 1'b1;
    step();
    chk("postrst_in_ready", 32'(o_in_ready), 1);
    chk("postrst_valid",    32'(o_out_valid), 0);
    i_in_data = 32'hA5; i_in_valid = 1'b1;
    step();
    i_in_valid = 1'b0;
    step();
    chk("a5_valid_early", 32'(o_out_valid), 0);
    step();
    chk("a5_valid", 32'(o_out_valid), 1);
    chk("a5_data",  o_out_data, 32'hA5);
    chk("a5_count", 32'(o_count), 1);
    i_out_ready = 1'b1;
    step();
    chk("a5_empty", 32'(o_empty), 1);
    step(); step();
    chk("a5_no_stale", 32'(o_out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_stream_fifo.md
BRAM_STREAM_FIFO -- requirements
Module: bram_stream_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each stored word.
REQ-002 Parameter ADDR_WIDTH, default 10: log2 of DEPTH; DEPTH = 2**ADDR_WIDTH total entries.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 i_in_valid  input  1  upstream word present on i_in_data.
REQ-006 o_in_ready  output  1  FIFO can accept a word this cycle.
REQ-007 i_in_data  input  DATA_WIDTH  write data.
REQ-008 o_out_valid  output  1  o_out_data holds the oldest word.
REQ-009 i_out_ready  input  1  downstream consumes the word this cycle.
REQ-010 o_out_data  output  DATA_WIDTH  head-of-queue data, first-word-fall-through.
REQ-011 o_count  output  ADDR_WIDTH+1  words held in total (memory plus output stage).
REQ-012 o_empty / o_full  output  1 each  o_count == 0 / o_count == DEPTH.

Function
REQ-013 Write transfer occurs when i_in_valid && o_in_ready; read transfer when o_out_valid && i_out_ready.
REQ-014 o_in_ready = (o_count < DEPTH), registered, never combinationally dependent on i_out_ready.
REQ-015 Storage: one dual-port BRAM, port A write-only (push), port B read-only (prefetch), both on clk; port-B read latency one cycle, read-during-write returns old data.
REQ-016 Output stage: 2-entry prefetch register (head + skid) between BRAM port B and o_out_data.
REQ-017 Prefetch read issued on port B when memory non-empty and output stage will have a free slot next cycle, counting reads already in flight.
REQ-018 Word written on edge N to an empty FIFO: o_out_valid high after edge N+2; no earlier.
REQ-019 With i_in_valid and i_out_ready held high in steady state: one word per clock each side, no bubbles.
REQ-020 Words emerge in exact write order; no duplication, no loss.
REQ-021 o_out_data and o_out_valid stable while o_out_valid && !i_out_ready.
REQ-022 Write and read pointers ADDR_WIDTH bits, wrap modulo DEPTH with no special case.
REQ-023 o_count: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-024 Simultaneous write and read while full: read accepted; write refused because o_in_ready was low that cycle.
REQ-025 i_in_valid while o_in_ready low: ignored, no state change; i_out_ready while o_out_valid low: ignored.

Reset
REQ-026 While rst low: pointers, o_count, in-flight flags cleared; o_out_valid 0, o_in_ready 0, o_empty 1, o_full 0, o_out_data 0.
REQ-027 First clock after rst high: o_in_ready 1.
REQ-028 Reset mid-operation discards all stored and in-flight words; BRAM contents not cleared and never re-emitted.

Structure
REQ-029 Shared package holds: default DATA_WIDTH/ADDR_WIDTH constants and the prefetch-stage occupancy encoding (0, 1, 2 entries).
REQ-030 Exactly one sub-module: dual_port_bram, instanced with the same clk on both ports, port-A read data and port-B write unused (b_wr tied 0).
REQ-031 Target size 120-400 lines RTL, no vendor primitives.

Verification
REQ-032 ADDR_WIDTH=4; push 0x11 once, i_out_ready high -> o_out_valid rises two edges after accept, o_out_data 0x11, o_empty returns 1.
REQ-033 Push 16 words 0..15 with i_out_ready low -> o_full 1, o_count 16, o_in_ready 0; 17th push ignored; then drain -> 0..15 in order, nothing else.
REQ-034 Continuous push/pop 100 incrementing words, both ready/valid high -> after 2-cycle fill, one output per clock, data matches, o_count constant.
REQ-035 Random i_in_valid / i_out_ready (50%) for 2000 words across many pointer wraps -> scoreboard order match, o_count always equals scoreboard depth.
REQ-036 Full FIFO, i_out_ready high and i_in_valid high same cycle -> one word out, o_count 15, next cycle o_in_ready 1.
REQ-037 rst low for one cycle with 7 words held and prefetch in flight -> o_out_valid 0, o_count 0 next cycle; subsequent push 0xA5 emerges first.
